reg_native_if_responder: RTL and testbench
==========================================

# reg_native_if_responder

Terminating responder for reg_native_if: accepts native requests, meaning the requests a regdisp forward port or CDC bridge delivers to a third-party-IP-side endpoint. It decodes them into a bank of REG_NUM read/write registers and returns ack_vld/err/rd_data after a fixed, parameterised latency. The team uses it as the stand-in third-party IP behind forwarding bridges, and as a minimal real register block for IPs without their own reg file. It handles one transaction at a time.

## Interface
- BUS_DATA_WIDTH, 32, data width; must be 8·2^k.
- BUS_ADDR_WIDTH, 64, address width.
- BASE_ADDR, 0, byte address of register 0; must be BUS_DATA_WIDTH/8 aligned.
- REG_NUM, 16, number of registers, 1..256.
- ACK_LATENCY, 1, cycles from accepted req_vld to ack_vld, 1..15.
- RESET_VAL, 0, BUS_DATA_WIDTH-bit reset value of every register.

Ports:
- native_clk  in  1  sole clock; everything is rising-edge.
- native_rst  in  1  reset. One clock; reset is synchronous and active-high.
- req_vld  in  1  request strobe, single-cycle pulse.
- addr  in  BUS_ADDR_WIDTH  byte address, sampled with req_vld.
- wr_en  in  1  write request, sampled with req_vld.
- rd_en  in  1  read request, sampled with req_vld.
- wr_data  in  BUS_DATA_WIDTH  write data, sampled with req_vld.
- ack_vld  out  1  completion strobe, one cycle per accepted request.
- err  out  1  error flag, valid only while ack_vld=1.
- rd_data  out  BUS_DATA_WIDTH  read data, valid only while ack_vld=1.
- reg_value  out  REG_NUM·BUS_DATA_WIDTH  flattened register contents; register i is in bits [i·W +: W].
- busy  out  1  a transaction is outstanding.
- drop_cnt  out  8  saturating count of requests ignored while busy.

## Operation
- FSM has two states, IDLE and PEND. Reset puts it in IDLE.
- IDLE with req_vld=1:
  - capture addr, wr_en, rd_en, wr_data;
  - load the latency counter with ACK_LATENCY−1;
  - go to PEND.
- PEND with counter≠0: decrement the counter.
- PEND with counter=0 (the ack cycle):
  - drive ack_vld=1;
  - execute the captured request;
  - if req_vld=1 in this same cycle, accept it as a new capture and stay in PEND (back-to-back); otherwise go to IDLE.
- req_vld=1 in PEND outside the ack cycle: the request is ignored; drop_cnt increments and saturates at 255.
- Address decode:
  - off = addr − BASE_ADDR, computed at full BUS_ADDR_WIDTH;
  - idx = off >> log2(BUS_DATA_WIDTH/8).
  - The request is mapped iff addr ≥ BASE_ADDR, off is word-aligned, and idx < REG_NUM.
- err=1 in the ack cycle when any of these holds:
  - the request is unmapped;
  - wr_en=rd_en=1;
  - wr_en=rd_en=0.
- On err: no register changes and rd_data=0.
- Good write: reg[idx] ← captured wr_data at the ack edge. rd_data=0.
- Good read: rd_data=reg[idx], the value before any update in that cycle.
- Registers change only through good writes.

## Timing
- Reset values: ack_vld=0, err=0, rd_data=0, busy=0, drop_cnt=0, all registers = RESET_VAL.
- ack_vld, err and rd_data are registered. The cycle after a request is accepted, busy=1.
- Request in cycle t → ack_vld=1 exactly in cycle t+ACK_LATENCY.
  - Exception: ACK_LATENCY=1 gives ack in t+1; the ack cycle is the cycle after capture.
- Write data appears on reg_value one cycle after ack_vld.
- busy=1 from t+1 through the ack cycle. In the cycle after the ack it is 0, unless a back-to-back request was captured.
- Maximum throughput: one request per ACK_LATENCY cycles.
- err and rd_data are 0 whenever ack_vld=0.
- native_rst asserted mid-transaction:
  - the transaction is aborted;
  - no ack is ever issued;
  - the pending write is discarded;
  - all outputs return to their reset values on the next edge.
- native_rst has priority over req_vld in the same cycle.

## Test plan
- Write then read, ACK_LATENCY=3, BASE_ADDR=0x1000: write 0xDEADBEEF to 0x1008 → ack in t+3, err=0; reg_value[95:64]=0xDEADBEEF one cycle later. Reading 0x1008 returns rd_data=0xDEADBEEF.
- Decode errors, REG_NUM=16: three requests each ack with err=1, rd_data=0 and no register change:
  - 0x1040 (idx 16);
  - 0x0FFC (below base);
  - 0x1002 (misaligned).
- Illegal ops: wr_en=rd_en=1 to 0x1000 → err=1, reg0 unchanged. wr_en=rd_en=0 → err=1.
- Back-to-back, ACK_LATENCY=1: req_vld held for 4 consecutive cycles (alternating write/read) → 4 acks on consecutive cycles, drop_cnt=0.
- Overrun, ACK_LATENCY=4: extra req_vld at t+1 and t+2 → a single ack at t+4, drop_cnt=2. Later, 300 overrun pulses → drop_cnt=255.
- Reset mid-operation: write to 0x1004 at t, native_rst at t+1 → no ack_vld, reg1=RESET_VAL, busy=0. The next request completes normally.

Source files
------------

// File: rtl/reg_native_if_responder.sv
// Terminating responder for native register requests: decodes into a bank of
// REG_NUM registers and acknowledges each request after ACK_LATENCY cycles.
module reg_native_if_responder #(
    parameter int                        BUS_DATA_WIDTH = 32,
    parameter int                        BUS_ADDR_WIDTH = 64,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        REG_NUM        = 16,
    parameter int                        ACK_LATENCY    = 1,
    parameter logic [BUS_DATA_WIDTH-1:0] RESET_VAL      = '0
) (
    input  logic                              native_clk,
    input  logic                              native_rst,
    input  logic                              req_vld,
    input  logic [BUS_ADDR_WIDTH-1:0]         addr,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [BUS_DATA_WIDTH-1:0]         wr_data,
    output logic                              ack_vld,
    output logic                              err,
    output logic [BUS_DATA_WIDTH-1:0]         rd_data,
    output logic [REG_NUM*BUS_DATA_WIDTH-1:0] reg_value,
    output logic                              busy,
    output logic [7:0]                        drop_cnt
);

    localparam int BYTES = BUS_DATA_WIDTH / 8;
    localparam int ALIGN = $clog2(BYTES);
    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    typedef enum logic {IDLE, PEND} state_t;

    state_t                      state, state_nxt;
    logic [3:0]                  cnt, cnt_nxt;
    logic [BUS_ADDR_WIDTH-1:0]   cap_addr;
    logic                        cap_wr, cap_rd;
    logic [BUS_DATA_WIDTH-1:0]   cap_wdata;
    logic [BUS_DATA_WIDTH-1:0]   regs [REG_NUM];

    logic                        ack_cycle, accept, drop;
    logic                        cur_wr_fire;
    logic [IDX_W-1:0]            cur_idx, eff_idx;
    logic [BUS_ADDR_WIDTH-1:0]   eff_addr;
    logic                        eff_wr, eff_rd, eff_ok;
    logic [BUS_DATA_WIDTH-1:0]   fwd_val;
    logic                        ack_nxt, err_nxt;
    logic [BUS_DATA_WIDTH-1:0]   rd_nxt;

    function automatic logic is_mapped(input logic [BUS_ADDR_WIDTH-1:0] a);
        logic [BUS_ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR)
            && ((off & BUS_ADDR_WIDTH'(BYTES - 1)) == '0)
            && ((off >> ALIGN) < BUS_ADDR_WIDTH'(REG_NUM));
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [BUS_ADDR_WIDTH-1:0] a);
        logic [BUS_ADDR_WIDTH-1:0] off;
        off = (a - BASE_ADDR) >> ALIGN;
        return off[IDX_W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign ack_cycle   = (state == PEND) && (cnt == 4'd0);
    assign accept      = req_vld && ((state == IDLE) || ack_cycle);
    assign drop        = req_vld && (state == PEND) && !ack_cycle;
    assign cur_idx     = to_idx(cap_addr);
    assign cur_wr_fire = ack_cycle && is_mapped(cap_addr) && cap_wr && !cap_rd;
    assign busy        = (state == PEND);

    // Outputs of the next ack cycle are prepared one edge early so they can be
    // registered; a same-cycle write to the read target is forwarded.
    assign eff_addr = accept ? addr  : cap_addr;
    assign eff_wr   = accept ? wr_en : cap_wr;
    assign eff_rd   = accept ? rd_en : cap_rd;
    assign eff_ok   = is_mapped(eff_addr) && (eff_wr ^ eff_rd);
    assign eff_idx  = to_idx(eff_addr);
    assign fwd_val  = (cur_wr_fire && (cur_idx == eff_idx)) ? cap_wdata : regs[eff_idx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        rd_nxt    = '0;
        if (accept) begin
            state_nxt = PEND;
            cnt_nxt   = 4'(ACK_LATENCY - 1);
        end else if (ack_cycle) begin
            state_nxt = IDLE;
        end else if (state == PEND) begin
            cnt_nxt = cnt - 4'd1;
        end
        ack_nxt = (accept && (ACK_LATENCY == 1)) || ((state == PEND) && (cnt == 4'd1));
        if (ack_nxt) begin
            err_nxt = !eff_ok;
            rd_nxt  = (eff_ok && eff_rd) ? fwd_val : '0;
        end
    end

    always_ff @(posedge native_clk) begin
        if (native_rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            ack_vld  <= 1'b0;
            err      <= 1'b0;
            rd_data  <= '0;
            drop_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ack_vld  <= ack_nxt;
            err      <= err_nxt;
            rd_data  <= rd_nxt;
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    always_ff @(posedge native_clk) begin
        if (accept) begin
            cap_addr  <= addr;
            cap_wr    <= wr_en;
            cap_rd    <= rd_en;
            cap_wdata <= wr_data;
        end
    end

    always_ff @(posedge native_clk) begin
        if (native_rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= RESET_VAL;
        end else if (cur_wr_fire) begin
            regs[cur_idx] <= cap_wdata;
        end
    end

    for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
        assign reg_value[g*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_reg_native_if_responder.sv
// Directed bench for reg_native_if_responder: three instances with
// ACK_LATENCY 3, 1 and 4, all at BASE_ADDR 0x1000 with 16 registers.
module tb_reg_native_if_responder;

    logic         clk;
    logic         rst;
    logic         req_vld [3];
    logic [63:0]  addr    [3];
    logic         wr_en   [3];
    logic         rd_en   [3];
    logic [31:0]  wr_data [3];
    logic         ack_vld [3];
    logic         err     [3];
    logic [31:0]  rd_data [3];
    logic [511:0] reg_value [3];
    logic         busy    [3];
    logic [7:0]   drop_cnt [3];

    int checks = 0;
    int errors = 0;

    reg_native_if_responder #(.BASE_ADDR(64'h1000), .REG_NUM(16), .ACK_LATENCY(3)) u_lat3 (
        .native_clk(clk), .native_rst(rst), .req_vld(req_vld[0]), .addr(addr[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .wr_data(wr_data[0]), .ack_vld(ack_vld[0]),
        .err(err[0]), .rd_data(rd_data[0]), .reg_value(reg_value[0]), .busy(busy[0]),
        .drop_cnt(drop_cnt[0]));

    reg_native_if_responder #(.BASE_ADDR(64'h1000), .REG_NUM(16), .ACK_LATENCY(1)) u_lat1 (
        .native_clk(clk), .native_rst(rst), .req_vld(req_vld[1]), .addr(addr[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .wr_data(wr_data[1]), .ack_vld(ack_vld[1]),
        .err(err[1]), .rd_data(rd_data[1]), .reg_value(reg_value[1]), .busy(busy[1]),
        .drop_cnt(drop_cnt[1]));

    reg_native_if_responder #(.BASE_ADDR(64'h1000), .REG_NUM(16), .ACK_LATENCY(4)) u_lat4 (
        .native_clk(clk), .native_rst(rst), .req_vld(req_vld[2]), .addr(addr[2]),
        .wr_en(wr_en[2]), .rd_en(rd_en[2]), .wr_data(wr_data[2]), .ack_vld(ack_vld[2]),
        .err(err[2]), .rd_data(rd_data[2]), .reg_value(reg_value[2]), .busy(busy[2]),
        .drop_cnt(drop_cnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic [63:0] a,
                           input logic w, input logic r, input logic [31:0] d);
        req_vld[k] = v;
        addr[k]    = a;
        wr_en[k]   = w;
        rd_en[k]   = r;
        wr_data[k] = d;
    endtask

    // Issue one request, wait (bounded) for its ack and check latency/err/rd_data.
    task automatic do_txn(input int k, input logic [63:0] a, input logic w, input logic r,
                          input logic [31:0] d, input int exp_lat, input logic exp_err,
                          input logic [31:0] exp_rd, input string tag);
        int n;
        set_req(k, 1'b1, a, w, r, d);
        step();
        set_req(k, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        n = 1;
        while (ack_vld[k] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 512'(n), 512'(exp_lat));
        check({tag, "_err"}, 512'(err[k]), 512'(exp_err));
        check({tag, "_rd"}, 512'(rd_data[k]), 512'(exp_rd));
    endtask

    initial begin
        logic [511:0] exp0;
        int acks;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) set_req(k, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            check("rst_ack", 512'(ack_vld[k]), 512'd0);
            check("rst_err", 512'(err[k]), 512'd0);
            check("rst_rd", 512'(rd_data[k]), 512'd0);
            check("rst_busy", 512'(busy[k]), 512'd0);
            check("rst_drop", 512'(drop_cnt[k]), 512'd0);
            check("rst_regs", reg_value[k], 512'd0);
        end
        rst = 1'b0;
        step();

        // Write then read at latency 3
        set_req(0, 1'b1, 64'h1008, 1'b1, 1'b0, 32'hDEADBEEF);
        step();
        set_req(0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        check("wr_busy_t1", 512'(busy[0]), 512'd1);
        check("wr_ack_t1", 512'(ack_vld[0]), 512'd0);
        step();
        check("wr_ack_t2", 512'(ack_vld[0]), 512'd0);
        step();
        check("wr_ack_t3", 512'(ack_vld[0]), 512'd1);
        check("wr_err_t3", 512'(err[0]), 512'd0);
        check("wr_rd_t3", 512'(rd_data[0]), 512'd0);
        check("wr_busy_t3", 512'(busy[0]), 512'd1);
        check("wr_reg_not_yet", 512'(reg_value[0][95:64]), 512'd0);
        step();
        check("wr_ack_t4", 512'(ack_vld[0]), 512'd0);
        check("wr_busy_t4", 512'(busy[0]), 512'd0);
        check("wr_reg2", 512'(reg_value[0][95:64]), 512'hDEADBEEF);
        step();
        do_txn(0, 64'h1008, 1'b0, 1'b1, 32'h0, 3, 1'b0, 32'hDEADBEEF, "rd_reg2");
        step();
        check("rd_idle_rd", 512'(rd_data[0]), 512'd0);

        // Decode errors and illegal ops leave the registers untouched
        exp0 = 512'd0;
        exp0[95:64] = 32'hDEADBEEF;
        do_txn(0, 64'h1040, 1'b1, 1'b0, 32'h11111111, 3, 1'b1, 32'h0, "dec_idx16");
        do_txn(0, 64'h0FFC, 1'b0, 1'b1, 32'h0, 3, 1'b1, 32'h0, "dec_below");
        do_txn(0, 64'h1002, 1'b1, 1'b0, 32'h22222222, 3, 1'b1, 32'h0, "dec_misalign");
        do_txn(0, 64'h1008, 1'b1, 1'b1, 32'h33333333, 3, 1'b1, 32'h0, "ill_both");
        do_txn(0, 64'h1000, 1'b0, 1'b0, 32'h44444444, 3, 1'b1, 32'h0, "ill_none");
        step();
        check("err_regs_unchanged", reg_value[0], exp0);

        // Reset in the cycle after a write is accepted
        set_req(0, 1'b1, 64'h1004, 1'b1, 1'b0, 32'h12345678);
        step();
        set_req(0, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 512'(busy[0]), 512'd0);
        check("mid_rst_ack", 512'(ack_vld[0]), 512'd0);
        acks = 0;
        repeat (5) begin
            step();
            if (ack_vld[0] === 1'b1) acks++;
        end
        check("mid_rst_no_ack", 512'(acks), 512'd0);
        check("mid_rst_regs", reg_value[0], 512'd0);
        do_txn(0, 64'h1004, 1'b0, 1'b1, 32'h0, 3, 1'b0, 32'h0, "post_rst_rd");
        do_txn(0, 64'h1004, 1'b1, 1'b0, 32'hCAFEF00D, 3, 1'b0, 32'h0, "post_rst_wr");
        step();
        check("post_rst_reg1", 512'(reg_value[0][63:32]), 512'hCAFEF00D);

        // Back-to-back at latency 1: four consecutive requests
        set_req(1, 1'b1, 64'h1000, 1'b1, 1'b0, 32'hA1A1A1A1);
        step();
        check("b2b_ack0", 512'(ack_vld[1]), 512'd1);
        check("b2b_rd0", 512'(rd_data[1]), 512'd0);
        set_req(1, 1'b1, 64'h1000, 1'b0, 1'b1, 32'h0);
        step();
        check("b2b_ack1", 512'(ack_vld[1]), 512'd1);
        check("b2b_rd1", 512'(rd_data[1]), 512'hA1A1A1A1);
        set_req(1, 1'b1, 64'h1004, 1'b1, 1'b0, 32'hB2B2B2B2);
        step();
        check("b2b_ack2", 512'(ack_vld[1]), 512'd1);
        check("b2b_err2", 512'(err[1]), 512'd0);
        set_req(1, 1'b1, 64'h1004, 1'b0, 1'b1, 32'h0);
        step();
        check("b2b_ack3", 512'(ack_vld[1]), 512'd1);
        check("b2b_rd3", 512'(rd_data[1]), 512'hB2B2B2B2);
        set_req(1, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        step();
        check("b2b_ack_end", 512'(ack_vld[1]), 512'd0);
        check("b2b_busy_end", 512'(busy[1]), 512'd0);
        check("b2b_drop", 512'(drop_cnt[1]), 512'd0);
        check("b2b_regs", 512'(reg_value[1][63:0]), 512'hB2B2B2B2A1A1A1A1);

        // Overrun at latency 4: two extra pulses dropped, single ack
        set_req(2, 1'b1, 64'h1000, 1'b1, 1'b0, 32'h00000055);
        step();
        check("ovr_busy_t1", 512'(busy[2]), 512'd1);
        set_req(2, 1'b1, 64'h1004, 1'b0, 1'b1, 32'h0);
        step();
        set_req(2, 1'b1, 64'h1004, 1'b0, 1'b1, 32'h0);
        step();
        set_req(2, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        check("ovr_ack_t3", 512'(ack_vld[2]), 512'd0);
        check("ovr_drop_t3", 512'(drop_cnt[2]), 512'd2);
        step();
        check("ovr_ack_t4", 512'(ack_vld[2]), 512'd1);
        check("ovr_err_t4", 512'(err[2]), 512'd0);
        step();
        check("ovr_ack_t5", 512'(ack_vld[2]), 512'd0);
        check("ovr_busy_t5", 512'(busy[2]), 512'd0);
        check("ovr_drop_t5", 512'(drop_cnt[2]), 512'd2);
        check("ovr_reg0", 512'(reg_value[2][31:0]), 512'h55);
        acks = 0;
        repeat (4) begin
            step();
            if (ack_vld[2] === 1'b1) acks++;
        end
        check("ovr_no_extra_ack", 512'(acks), 512'd0);

        // Held request: three drops per transaction until saturation
        set_req(2, 1'b1, 64'h1000, 1'b0, 1'b1, 32'h0);
        repeat (420) step();
        set_req(2, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        repeat (6) step();
        check("sat_drop", 512'(drop_cnt[2]), 512'd255);
        check("sat_busy", 512'(busy[2]), 512'd0);
        check("sat_reg0", 512'(reg_value[2][31:0]), 512'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
